// File: rtl/vx_barrier_ctrl_pkg.sv
// Shared types and widths for the per-core barrier sequencer.
//   bar_state_e : per-slot lifecycle (IDLE, COLLECT, GREADY, GWAIT)
//   bar_req_t   : one barrier-instruction arrival as seen by the sequencer
//   gbar_req_t  : payload held on the global barrier request channel
//   gbar_rsp_t  : payload of a global release broadcast
// Bus structs are sized from the BAR_* defaults below; the top-level
// parameters default to the same values.
package vx_barrier_ctrl_pkg;

  localparam int unsigned BAR_NUM_WARPS    = 8;
  localparam int unsigned BAR_NUM_BARRIERS = 4;
  localparam int unsigned BAR_SIZE_W       = 8;
  localparam int unsigned BAR_NC_WIDTH     = 4;
  localparam int unsigned BAR_WID_W        = $clog2(BAR_NUM_WARPS);
  localparam int unsigned BAR_BID_W        = $clog2(BAR_NUM_BARRIERS);
  // One extra bit so the arrival counter can hold NUM_WARPS without wrapping.
  localparam int unsigned BAR_CTR_W        = BAR_WID_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    GREADY  = 2'd2,
    GWAIT   = 2'd3
  } bar_state_e;

  typedef struct packed {
    logic [BAR_BID_W-1:0]  id;
    logic                  is_global;
    logic                  is_noop;
    logic [BAR_SIZE_W-1:0] size_m1;
  } bar_req_t;

  typedef struct packed {
    logic [BAR_BID_W-1:0]    id;
    logic [BAR_SIZE_W-1:0]   size_m1;
    logic [BAR_NC_WIDTH-1:0] core_id;
  } gbar_req_t;

  typedef struct packed {
    logic [BAR_BID_W-1:0] id;
  } gbar_rsp_t;

  // One-hot warp mask for a warp id.
  function automatic logic [BAR_NUM_WARPS-1:0] warp_onehot(input logic [BAR_WID_W-1:0] wid);
    return BAR_NUM_WARPS'(1) << wid;
  endfunction

endpackage

// File: rtl/vx_barrier_ctrl_slot.sv
// One barrier slot: lifecycle FSM, stalled-warp mask and arrival counter.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   arr_valid            non-noop arrival addressed to this slot
//   arr_wid              arriving warp
//   arr_is_global        arrival is for a global barrier
//   arr_size_m1          local: warps-1, global: cores-1
//   active_warps         active warps (global completion test)
//   grant                this slot won request arbitration (only while GREADY)
//   rsp_hit              global release broadcast addressed to this slot
//   done_local_c         local barrier completes at the coming edge
//   done_rsp_c           global barrier released at the coming edge
//   greq_c               slot is waiting for the request channel
//   release_mask_c       warps to unstall at the coming edge
//   gsize_m1             core count - 1 captured from the global arrivals
//   err_c                protocol violation this cycle
//   busy_next_c          slot will be non-IDLE after the coming edge
module vx_barrier_slot
  import vx_barrier_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arr_valid,
  input  logic [BAR_WID_W-1:0]     arr_wid,
  input  logic                     arr_is_global,
  input  logic [BAR_SIZE_W-1:0]    arr_size_m1,
  input  logic [BAR_NUM_WARPS-1:0] active_warps,
  input  logic                     grant,
  input  logic                     rsp_hit,
  output logic                     done_local_c,
  output logic                     done_rsp_c,
  output logic                     greq_c,
  output logic [BAR_NUM_WARPS-1:0] release_mask_c,
  output logic [BAR_SIZE_W-1:0]    gsize_m1,
  output logic                     err_c,
  output logic                     busy_next_c
);

  bar_state_e               state, state_n;
  logic [BAR_NUM_WARPS-1:0] mask, mask_n;
  logic [BAR_CTR_W-1:0]     ctr, ctr_n;
  logic                     is_global, is_global_n;
  logic [BAR_SIZE_W-1:0]    gsize_n;
  logic [BAR_NUM_WARPS-1:0] arr_bit;
  logic [BAR_NUM_WARPS-1:0] arr_mask;
  logic                     arr_bad;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mask      <= '0;
      ctr       <= '0;
      is_global <= 1'b0;
      gsize_m1  <= '0;
    end else begin
      state     <= state_n;
      mask      <= mask_n;
      ctr       <= ctr_n;
      is_global <= is_global_n;
      gsize_m1  <= gsize_n;
    end
  end

  // Next state: arrival, arbitration grant and global response.
  always_comb begin
    state_n        = state;
    mask_n         = mask;
    ctr_n          = ctr;
    is_global_n    = is_global;
    gsize_n        = gsize_m1;
    done_local_c   = 1'b0;
    done_rsp_c     = 1'b0;
    release_mask_c = '0;
    err_c          = 1'b0;

    arr_bit  = warp_onehot(arr_wid);
    arr_mask = mask | arr_bit;
    // Duplicate warp, slot locked on the request channel, or kind mismatch.
    arr_bad  = (state == GREADY) || (state == GWAIT) || ((mask & arr_bit) != '0) ||
               ((state == COLLECT) && (is_global != arr_is_global));

    if (arr_valid) begin
      if (arr_bad) begin
        err_c = 1'b1;
      end else if (!arr_is_global) begin
        // Compare before the increment: this arrival is the last one.
        if (BAR_SIZE_W'(ctr) == arr_size_m1) begin
          done_local_c   = 1'b1;
          release_mask_c = arr_mask;
          state_n        = IDLE;
          mask_n         = '0;
          ctr_n          = '0;
          is_global_n    = 1'b0;
        end else begin
          state_n     = COLLECT;
          mask_n      = arr_mask;
          ctr_n       = ctr + BAR_CTR_W'(1);
          is_global_n = 1'b0;
        end
      end else begin
        mask_n      = arr_mask;
        is_global_n = 1'b1;
        gsize_n     = arr_size_m1;
        state_n     = (arr_mask == active_warps) ? GREADY : COLLECT;
      end
    end

    // Grants only target GREADY slots, which never accept arrivals.
    if (grant) begin
      state_n = GWAIT;
    end

    if (rsp_hit) begin
      if (state == GWAIT) begin
        done_rsp_c     = 1'b1;
        release_mask_c = release_mask_c | mask;
        state_n        = IDLE;
        mask_n         = '0;
        ctr_n          = '0;
        is_global_n    = 1'b0;
      end else begin
        err_c = 1'b1;
      end
    end

    greq_c      = (state == GREADY);
    busy_next_c = (state_n != IDLE);
  end

endmodule

// File: rtl/vx_barrier_ctrl.sv
// Per-core barrier sequencer feeding the warp scheduler.
// Tracks arrivals at NUM_BARRIERS local/global barrier slots, issues one
// registered release pulse per cycle, arbitrates completed global barriers
// onto the single-outstanding gbar request channel and matches responses.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   bar_valid/...       barrier instruction arrival (wid, id, global, noop, size_m1)
//   active_warps        active warps for the global completion test
//   release_valid/mask  registered unstall pulse and warp mask
//   gbar_req_*          global barrier request channel (valid held until ready)
//   gbar_rsp_valid/id   global release broadcast
//   err_pulse           one-cycle protocol violation flag
//   busy                any slot non-IDLE or a request pending
module vx_barrier_ctrl
  import vx_barrier_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WARPS    = BAR_NUM_WARPS,
  parameter int unsigned NUM_BARRIERS = BAR_NUM_BARRIERS,
  parameter int unsigned SIZE_W       = BAR_SIZE_W,
  parameter int unsigned CORE_ID      = 0,
  parameter int unsigned NC_WIDTH     = BAR_NC_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            bar_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]    bar_wid,
  input  logic [$clog2(NUM_BARRIERS)-1:0] bar_id,
  input  logic                            bar_is_global,
  input  logic                            bar_is_noop,
  input  logic [SIZE_W-1:0]               bar_size_m1,
  input  logic [NUM_WARPS-1:0]            active_warps,
  output logic                            release_valid,
  output logic [NUM_WARPS-1:0]            release_mask,
  output logic                            gbar_req_valid,
  input  logic                            gbar_req_ready,
  output logic [$clog2(NUM_BARRIERS)-1:0] gbar_req_id,
  output logic [SIZE_W-1:0]               gbar_req_size_m1,
  output logic [NC_WIDTH-1:0]             gbar_req_core_id,
  input  logic                            gbar_rsp_valid,
  input  logic [$clog2(NUM_BARRIERS)-1:0] gbar_rsp_id,
  output logic                            err_pulse,
  output logic                            busy
);

  bar_req_t                  arr;
  gbar_rsp_t                 rsp;
  gbar_req_t                 req_q, req_n;
  logic                      req_valid_q, req_valid_n;

  logic [NUM_BARRIERS-1:0]   slot_done_local;
  logic [NUM_BARRIERS-1:0]   slot_done_rsp;
  logic [NUM_BARRIERS-1:0]   slot_greq;
  logic [NUM_BARRIERS-1:0]   slot_err;
  logic [NUM_BARRIERS-1:0]   slot_busy_n;
  logic [NUM_BARRIERS-1:0]   slot_grant;
  logic [NUM_WARPS-1:0]      slot_rel  [NUM_BARRIERS];
  logic [SIZE_W-1:0]         slot_size [NUM_BARRIERS];

  logic                      grant_found;
  logic                      rel_valid_n;
  logic [NUM_WARPS-1:0]      rel_mask_n;
  logic                      err_n;
  logic                      busy_n;

  // Bundle the incoming instruction and response.
  always_comb begin
    arr         = '0;
    arr.id      = bar_id;
    arr.is_global = bar_is_global;
    arr.is_noop = bar_is_noop;
    arr.size_m1 = bar_size_m1;
    rsp         = '0;
    rsp.id      = gbar_rsp_id;
  end

  // Barrier slots.
  for (genvar i = 0; i < NUM_BARRIERS; i++) begin : g_slot
    vx_barrier_slot u_slot (
      .clk            (clk),
      .reset          (reset),
      .arr_valid      (bar_valid && !arr.is_noop && (arr.id == BAR_BID_W'(i))),
      .arr_wid        (bar_wid),
      .arr_is_global  (arr.is_global),
      .arr_size_m1    (arr.size_m1),
      .active_warps   (active_warps),
      .grant          (slot_grant[i]),
      .rsp_hit        (gbar_rsp_valid && (rsp.id == BAR_BID_W'(i))),
      .done_local_c   (slot_done_local[i]),
      .done_rsp_c     (slot_done_rsp[i]),
      .greq_c         (slot_greq[i]),
      .release_mask_c (slot_rel[i]),
      .gsize_m1       (slot_size[i]),
      .err_c          (slot_err[i]),
      .busy_next_c    (slot_busy_n[i])
    );
  end

  // Lowest-index GREADY slot wins, and only while the channel is empty.
  always_comb begin
    slot_grant  = '0;
    grant_found = 1'b0;
    if (!req_valid_q) begin
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        if (slot_greq[i] && !grant_found) begin
          slot_grant[i] = 1'b1;
          grant_found   = 1'b1;
        end
      end
    end
  end

  // Request register: load on grant, drop on handshake.
  always_comb begin
    req_valid_n = req_valid_q;
    req_n       = req_q;
    if (req_valid_q && gbar_req_ready) begin
      req_valid_n = 1'b0;
    end
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      if (slot_grant[i]) begin
        req_valid_n   = 1'b1;
        req_n.id      = BAR_BID_W'(i);
        req_n.size_m1 = slot_size[i];
        req_n.core_id = BAR_NC_WIDTH'(CORE_ID);
      end
    end
  end

  // Noop, local completions and global releases merge into one pulse.
  always_comb begin
    rel_valid_n = bar_valid && arr.is_noop;
    rel_mask_n  = (bar_valid && arr.is_noop) ? warp_onehot(bar_wid) : '0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      rel_valid_n = rel_valid_n | slot_done_local[i] | slot_done_rsp[i];
      rel_mask_n  = rel_mask_n | slot_rel[i];
    end
    err_n  = |slot_err;
    busy_n = (|slot_busy_n) || req_valid_n;
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      release_valid <= 1'b0;
      release_mask  <= '0;
      req_valid_q   <= 1'b0;
      req_q         <= '0;
      err_pulse     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      release_valid <= rel_valid_n;
      release_mask  <= rel_mask_n;
      req_valid_q   <= req_valid_n;
      req_q         <= req_n;
      err_pulse     <= err_n;
      busy          <= busy_n;
    end
  end

  assign gbar_req_valid   = req_valid_q;
  assign gbar_req_id      = req_q.id;
  assign gbar_req_size_m1 = req_q.size_m1;
  assign gbar_req_core_id = req_q.core_id;

endmodule
